// File: rtl/arb_pkg.sv
// Shared types and defaults for the round-robin arbiter slice.
// Optional timeout-suppression lock is enabled by defining ARB_LOCK_EN.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    TURN
  } arb_state_t;

  localparam int ARB_N        = 8;
  localparam int ARB_MAX_HOLD = 16;

  // Binary index of a one-hot vector of up to 16 bits; all-zero maps to 0.
  function automatic logic [3:0] onehot_to_index(input logic [15:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (oh[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
// The lock line exists only when ARB_LOCK_EN is defined.
interface rr_arbiter_if
  import arb_pkg::*;
#(
  parameter int N   = ARB_N,
  parameter int IDW = $clog2(N)
);
  logic [N-1:0]   req;
`ifdef ARB_LOCK_EN
  logic           lock;
`endif
  logic [N-1:0]   grant;
  logic           grant_valid;
  logic [IDW-1:0] grant_id;
  logic           busy;

  modport master (
`ifdef ARB_LOCK_EN
    output lock,
`endif
    output req,
    input  grant, grant_valid, grant_id, busy
  );

  modport slave (
`ifdef ARB_LOCK_EN
    input  lock,
`endif
    input  req,
    output grant, grant_valid, grant_id, busy
  );
endinterface

// File: rtl/lowbit_picker.sv
// One-hot isolation of the lowest set bit; all-zero input yields all-zero output.
module lowbit_picker #(
  parameter int N = 8
) (
  input  logic [N-1:0] vec,
  output logic [N-1:0] onehot
);
  assign onehot = vec & (~vec + N'(1));
endmodule

// File: rtl/rr_arbiter.sv
// Registered round-robin arbiter with hold-time limit and one-cycle turnaround.
// Define ARB_LOCK_EN to let the owner suppress timeout preemption via lock.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int N        = ARB_N,
  parameter int MAX_HOLD = ARB_MAX_HOLD,
  parameter int IDW      = $clog2(N)
) (
  input logic        clk,
  input logic        reset,
  rr_arbiter_if.slave arb
);
  localparam int HW = $clog2(MAX_HOLD + 1);

  arb_state_t     state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] owner;
  logic [HW-1:0]  hold_cnt;
  logic [N-1:0]   grant_q;
  logic           grant_valid_q;
  logic           busy_q;

  logic [N-1:0]   prio_mask, masked, pick_m, pick_u, winner;
  logic [IDW-1:0] win_id;
  logic           owner_req, others, timeout, rel;

  always_comb begin
    prio_mask = '0;
    for (int unsigned i = 0; i < N; i++) begin
      prio_mask[i] = (IDW'(i) >= ptr);
    end
  end

  assign masked = arb.req & prio_mask;

  lowbit_picker #(.N(N)) u_pick_masked (.vec(masked),  .onehot(pick_m));
  lowbit_picker #(.N(N)) u_pick_all    (.vec(arb.req), .onehot(pick_u));

  assign winner    = (|masked) ? pick_m : pick_u;
  assign win_id    = IDW'(onehot_to_index(16'(winner)));
  assign owner_req = arb.req[owner];
  assign others    = |(arb.req & ~grant_q);
`ifdef ARB_LOCK_EN
  assign timeout   = (hold_cnt == HW'(MAX_HOLD)) && others && !arb.lock;
`else
  assign timeout   = (hold_cnt == HW'(MAX_HOLD)) && others;
`endif
  assign rel       = !owner_req || timeout;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      ptr           <= '0;
      owner         <= '0;
      hold_cnt      <= '0;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      case (state)
        // IDLE and TURN share arbitration; busy is already low in IDLE.
        IDLE, TURN: begin
          if (|arb.req) begin
            grant_q       <= winner;
            grant_valid_q <= 1'b1;
            owner         <= win_id;
            hold_cnt      <= HW'(1);
            busy_q        <= 1'b1;
            state         <= GRANT;
          end else begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        GRANT: begin
          if (rel) begin
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            owner         <= '0;
            ptr           <= owner + IDW'(1);
            hold_cnt      <= '0;
            state         <= TURN;
          end else if (hold_cnt != HW'(MAX_HOLD)) begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign arb.grant       = grant_q;
  assign arb.grant_valid = grant_valid_q;
  assign arb.grant_id    = owner;
  assign arb.busy        = busy_q;

  a_grant_onehot0: assert property (@(posedge clk) $onehot0(grant_q));

endmodule

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
- Sequential round-robin arbiter sharing one resource among N requesters.
- The grant is registered and held for the whole transaction.
- The grant is released when the owner drops its request or when a hold-time limit expires.
- Priority rotates so the last owner becomes lowest priority; reuses a one-hot lowest-bit picker as the combinational core.

Parameters:
- N, 8, number of requesters (power of two, 2..16).
- MAX_HOLD, 16, max consecutive cycles one owner may hold the grant (>=1).
- IDW, $clog2(N), width of grant_id.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  N  request lines; requester i holds req[i]=1 while it wants or uses the resource.
- lock  input  1  only when ARB_LOCK_EN is defined; owner asserts it to suppress timeout preemption.
- grant  output  N  registered one-hot grant, all-zero when idle.
- grant_valid  output  1  OR of grant, registered.
- grant_id  output  IDW  binary index of the current owner; 0 when grant_valid=0.
- busy  output  1  high in GRANT and TURN states.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - grant=0, grant_valid=0, grant_id=0, busy=0.
  - state=IDLE, ptr=0, hold_cnt=0.
- ptr is the index of the highest-priority requester. Priority order is ptr, ptr+1, ..., ptr-1, mod N.
- Selection, combinational:
  - masked = req & {bits >= ptr}.
  - If masked != 0, the winner is the lowest set bit of masked.
  - Otherwise the winner is the lowest set bit of req.
- States:
  - IDLE: if req != 0, register the winner into grant and grant_id, set hold_cnt=1, go to GRANT. Latency is 1 cycle from req to grant.
  - GRANT: owner holds the grant.
    - Release if req[owner]=0, or if hold_cnt==MAX_HOLD and some other req bit is set.
    - On release: grant<=0, ptr<=(owner+1) mod N, go to TURN.
    - Otherwise hold_cnt increments, saturating at MAX_HOLD.
  - TURN: exactly one dead cycle with grant=0 (resource turnaround). Then:
    - If req != 0, grant the new winner using the updated ptr and go to GRANT.
    - If req == 0, go to IDLE.
- Timeout with no competitor: if the owner is the only requester at MAX_HOLD, it keeps the grant and hold_cnt stays saturated. Preemption happens the first cycle another req appears.
- Preempted owner: its req may stay high; it competes again at lowest priority.
- Grant is never combinationally dependent on req in the same cycle. Grant changes only on a clock edge.
- Simultaneous owner drop and timeout: treated as one release, a single TURN cycle.
- Requests arriving during TURN are seen at the TURN→GRANT edge.
- Reset mid-grant: all outputs are zero on the next cycle and ptr returns to 0.
- Width rules:
  - hold_cnt width is $clog2(MAX_HOLD+1).
  - ptr wraps from N-1 to 0.
- Invariant: at most one grant bit is ever set (checked by assertion).

Optional Feature:
- Macro ARB_LOCK_EN.
- When defined:
  - The lock port exists.
  - While lock=1 in GRANT, timeout preemption is suppressed; release occurs only on req[owner]=0.
  - hold_cnt still saturates.
  - lock is ignored outside GRANT.
- When undefined:
  - No lock port.
  - Timeout preemption always applies.

Decomposition:
- Shared package arb_pkg holds:
  - The state enum: IDLE, GRANT, TURN.
  - Default constants ARB_N=8 and ARB_MAX_HOLD=16.
  - A function onehot_to_index.
- One sub-module: lowbit_picker (N-bit in, N-bit one-hot out, lowest set bit wins, all-zero in gives all-zero out). It is instantiated twice, for the masked and the unmasked vectors.

Test Plan:
- Reset, then req=8'b0000_0000 for 5 cycles -> grant=0, grant_valid=0, busy=0 throughout.
- req=8'b0010_0100 at cycle 0 -> grant=8'b0000_0100 (id 2) at cycle 1. Drop req[2] -> one TURN cycle with grant=0, then grant=8'b0010_0000 (id 5), ptr=3 at grant time.
- Hold req=8'hFF continuously -> grants rotate 0,1,2,...,7,0. Each owner holds exactly MAX_HOLD=16 cycles, with one zero-grant cycle between owners.
- Single requester req=8'b1000_0000 held for 40 cycles -> grant stays on bit 7 for all 40 cycles, no TURN. Raise req[0] at cycle 30 -> release at the next edge; bit 0 is granted after one TURN cycle.
- Assert reset in the middle of a grant to id 4 -> next cycle grant=0, state IDLE. With req=8'b0001_0001 after reset, id 0 wins (ptr=0).
- ARB_LOCK_EN defined: owner 3 with lock=1 and req=8'b0000_1001 for 30 cycles -> no preemption. Deassert lock -> release at the next edge (hold_cnt already saturated), then grant to id 0 after TURN.
